dmem_sized_port: RTL and testbench

- Parametrised successor to the core's word-only data memory.
- Adds byte, half and word loads and stores using RISC-V funct3 encoding, per-byte write lanes, misalignment and illegal-size error reporting, and a configurable wait-state latency behind a valid/ready handshake.
- Sits between the LSU and the data array.
- Intended for both the single-cycle core (LATENCY=0) and later multi-cycle/pipelined cores.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_sized_port_if.sv | 25 ++
 rtl/dmem_sized_port_lane_fmt.sv | 77 +++++++
 rtl/dmem_sized_port.sv | 167 ++++++++++++++++
 tb/tb_dmem_sized_port.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the sized data-memory port: funct3 access codes,
// FSM state encoding and the data width.
package dmem_pkg;

    localparam int DATA_W = 32;

    // RISC-V load/store funct3 size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_sized_port_if.sv
// Request/response bus between the LSU (master) and the sized data memory (slave).
interface dmem_sized_port_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_sized_port_lane_fmt.sv
// Combinational lane logic: store strobes and replicated data, alignment and
// legality checks for the incoming request, and load extract/extend for the
// captured word.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_lane,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [3:0]        o_wstrb,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_misaligned,
    output logic              o_illegal,
    input  logic [2:0]        i_ld_funct3,
    input  logic [1:0]        i_ld_lane,
    input  logic [DATA_W-1:0] i_ld_word,
    output logic [DATA_W-1:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store strobes, lane-replicated data and fault flags from size and offset
    always_comb begin
        o_wstrb      = 4'b0000;
        o_wdata      = i_wdata;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_wstrb = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                o_wstrb      = i_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
                o_misaligned = i_lane[0];
            end
            F3_W: begin
                o_wstrb      = 4'b1111;
                o_misaligned = (i_lane != 2'b00);
            end
            F3_BU: begin
                // unsigned sizes only exist for loads
                o_illegal = i_we;
            end
            F3_HU: begin
                o_misaligned = i_lane[0];
                o_illegal    = i_we;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

    // Pick the addressed byte/half of the captured word and extend it
    always_comb begin
        case (i_ld_lane)
            2'd0:    w_byte = i_ld_word[7:0];
            2'd1:    w_byte = i_ld_word[15:8];
            2'd2:    w_byte = i_ld_word[23:16];
            default: w_byte = i_ld_word[31:24];
        endcase
        w_half = i_ld_lane[1] ? i_ld_word[31:16] : i_ld_word[15:0];
        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_ld_data = {24'h000000, w_byte};
            F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_ld_data = {16'h0000, w_half};
            F3_W:    o_ld_data = i_ld_word;
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/dmem_sized_port.sv
// Sized data-memory port: byte/half/word loads and stores behind a
// valid/ready handshake with LATENCY wait cycles before each response.
// Optional build macro DMEM_RANGE_CHECK_EN faults addresses >= DEPTH*4;
// without it the address wraps modulo DEPTH*4 bytes.
module dmem_sized_port
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 0
) (
    input  logic             CLK,
    input  logic             rst,
    dmem_sized_port_if.slave bus
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    dmem_state_t       r_state;
    logic [3:0]        r_cnt;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic              r_ld_ok;
    logic [2:0]        r_ld_funct3;
    logic [1:0]        r_ld_lane;

    logic [IDX_W-1:0]  w_idx;
    logic [1:0]        w_lane;
    logic [3:0]        w_wstrb;
    logic [DATA_W-1:0] w_wdata_rep;
    logic              w_misaligned;
    logic              w_illegal;
    logic              w_range_err;
    logic              w_fault;
    logic              w_accept;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_ld_data;

    assign w_idx  = bus.req_addr[IDX_W+1:2];
    assign w_lane = bus.req_addr[1:0];

    dmem_lane_fmt u_lane_fmt (
        .i_funct3     (bus.req_funct3),
        .i_lane       (w_lane),
        .i_we         (bus.req_we),
        .i_wdata      (bus.req_wdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata_rep),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal),
        .i_ld_funct3  (r_ld_funct3),
        .i_ld_lane    (r_ld_lane),
        .i_ld_word    (w_rd_word),
        .o_ld_data    (w_ld_data)
    );

`ifdef DMEM_RANGE_CHECK_EN
    generate
        if (ADDR_W > IDX_W + 2) begin : g_range
            assign w_range_err = |bus.req_addr[ADDR_W-1:IDX_W+2];
        end else begin : g_no_range
            assign w_range_err = 1'b0;
        end
    endgenerate
`else
    assign w_range_err = 1'b0;
    generate
        if (ADDR_W > IDX_W + 2) begin : g_wrap
            // high address bits are deliberately dropped so accesses wrap
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^bus.req_addr[ADDR_W-1:IDX_W+2];
        end
    endgenerate
`endif

    assign w_fault  = w_misaligned | w_illegal | w_range_err;
    // the array has no reset, so keep it from firing while rst is asserted
    assign w_accept = rst && (r_state == IDLE) && bus.req_valid;
    assign w_wr_en  = w_accept &&  bus.req_we && !w_fault;
    assign w_rd_en  = w_accept && !bus.req_we && !w_fault;

    // One byte-wide array per lane so each lane has its own write enable
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rd_byte;

            // Lane write at accept, registered read captured for loads
            always_ff @(posedge CLK) begin
                if (w_wr_en && w_wstrb[gi]) begin
                    r_mem[w_idx] <= w_wdata_rep[8*gi +: 8];
                end
                if (w_rd_en) begin
                    r_rd_byte <= r_mem[w_idx];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_rd_byte;
        end
    endgenerate

    // Request/wait/response sequencing with registered handshake outputs
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_ld_ok     <= 1'b0;
            r_ld_funct3 <= F3_W;
            r_ld_lane   <= 2'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_rsp_err   <= w_fault;
                        r_ld_ok     <= !bus.req_we && !w_fault;
                        r_ld_funct3 <= bus.req_funct3;
                        r_ld_lane   <= w_lane;
                        r_req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_ld_ok     <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    // stores and faults return zero; loads return the formatted captured word
    assign bus.rsp_rdata = r_ld_ok ? w_ld_data : '0;

endmodule

// File: tb/tb_dmem_sized_port.sv
// Self-checking bench for dmem_sized_port: directed scenarios plus randomized
// traffic against a byte-addressed reference model.
module tb_dmem_sized_port;
    import dmem_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam int LAT    = 3;
    localparam int NBYTES = DEPTH * 4;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    always #5 CLK = ~CLK;

    dmem_sized_port_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_sized_port #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] m_mem [NBYTES];

    // Reference: fault rules from access size, alignment and legality
    function automatic logic m_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int  sz;
        logic legal;
`ifdef DMEM_RANGE_CHECK_EN
        if (a >= NBYTES) return 1'b1;
`endif
        if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 1'b1;
        sz = 1 << f3[1:0];
        return (a % sz) != 0;
    endfunction

    // Reference: expected response, applying stores to the byte model
    task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int sz;
        int base;
        logic [31:0] v;
        er = m_fault(we, f3, a);
        rd = 32'h0;
        if (er) return;
        sz   = 1 << f3[1:0];
        base = int'(a % NBYTES);
        if (we) begin
            for (int i = 0; i < sz; i++) begin
                v = wd >> (8 * i);
                m_mem[base + i] = v[7:0];
            end
        end else begin
            v = 32'h0;
            for (int i = 0; i < sz; i++) v = v | (32'(m_mem[base + i]) << (8 * i));
            if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
            if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
            rd = v;
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        @(negedge CLK);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        n = 0;
        while (!bus.req_ready && n < 64) begin
            @(negedge CLK);
            n++;
        end
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL issue_ready addr=%h: req_ready=%b required 1", a, bus.req_ready);
        end
        @(posedge CLK);
        @(negedge CLK);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 64) begin
            @(negedge CLK);
            lat++;
        end
        if (bus.rsp_valid !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1 within 64 cycles", bus.rsp_valid);
        end
    endtask

    task automatic finish_rsp;
        bus.rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        issue(we, f3, a, wd);
        wait_rsp(lat);
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        finish_rsp();
    endtask

    task automatic test_reset;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        total += 4;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
        if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h required 0", bus.rsp_rdata); end
        if (bus.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b required 0", bus.rsp_err); end
        $display("reset: req_ready=%b rsp_valid=%b", bus.req_ready, bus.rsp_valid);
    endtask

    task automatic test_prefill;
        logic [31:0] rd, erd, wd;
        logic er, eer;
        int lat;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            model_txn(1'b1, F3_W, 32'(w * 4), wd, erd, eer);
            do_txn(1'b1, F3_W, 32'(w * 4), wd, rd, er, lat);
            total += 2;
            if (er !== eer || rd !== erd) begin bad++; $display("FAIL prefill_rsp @%h: err=%b rdata=%h required err=%b rdata=%h", w * 4, er, rd, eer, erd); end
            if (lat != LAT + 1) begin bad++; $display("FAIL prefill_lat @%h: lat=%0d required %0d", w * 4, lat, LAT + 1); end
        end
        $display("prefill: 64 words written");
    endtask

    task automatic test_sized_loads;
        logic [2:0]  f3s [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
        logic [31:0] adr [5] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
        logic [31:0] exp [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hDEADBEEF};
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        model_txn(1'b1, F3_W, 32'h10, 32'hDEADBEEF, erd, eer);
        do_txn(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, er, lat);
        for (int i = 0; i < 5; i++) begin
            model_txn(1'b0, f3s[i], adr[i], 32'h0, erd, eer);
            do_txn(1'b0, f3s[i], adr[i], 32'h0, rd, er, lat);
            total += 2;
            if (rd !== exp[i]) begin bad++; $display("FAIL sized_load_data f3=%0d @%h: got %h required %h", f3s[i], adr[i], rd, exp[i]); end
            if (er !== 1'b0) begin bad++; $display("FAIL sized_load_err f3=%0d @%h: got %b required 0", f3s[i], adr[i], er); end
            $display("load f3=%0d @%h -> %h err=%b", f3s[i], adr[i], rd, er);
        end
    endtask

    task automatic test_range;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        model_txn(1'b0, F3_W, 32'h1010, 32'h0, erd, eer);
        do_txn(1'b0, F3_W, 32'h1010, 32'h0, rd, er, lat);
        total += 2;
`ifdef DMEM_RANGE_CHECK_EN
        if (er !== 1'b1) begin bad++; $display("FAIL range_err: got %b required 1", er); end
        if (rd !== 32'h0) begin bad++; $display("FAIL range_data: got %h required 0", rd); end
`else
        if (er !== 1'b0) begin bad++; $display("FAIL wrap_err: got %b required 0", er); end
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL wrap_data: got %h required deadbeef", rd); end
`endif
        $display("LW @1010 -> %h err=%b", rd, er);
    endtask

    task automatic test_partial_stores;
        logic [2:0]  f3s [3] = '{F3_W, F3_B, F3_H};
        logic [31:0] adr [3] = '{32'h20, 32'h21, 32'h22};
        logic [31:0] wds [3] = '{32'h11223344, 32'h000000AA, 32'h0000BBCC};
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        for (int i = 0; i < 3; i++) begin
            model_txn(1'b1, f3s[i], adr[i], wds[i], erd, eer);
            do_txn(1'b1, f3s[i], adr[i], wds[i], rd, er, lat);
            total++;
            if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL store_rsp f3=%0d @%h: err=%b rdata=%h required 0/0", f3s[i], adr[i], er, rd); end
        end
        model_txn(1'b0, F3_W, 32'h20, 32'h0, erd, eer);
        do_txn(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'hBBCCAA44) begin bad++; $display("FAIL merged_word: got %h required bbccaa44", rd); end
        $display("merged LW @20 -> %h", rd);
    endtask

    task automatic test_faults;
        logic        wes [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s [5] = '{F3_W, F3_H, 3'b011, F3_BU, F3_W};
        logic [31:0] adr [5] = '{32'h22, 32'h01, 32'h20, 32'h20, 32'h21};
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        for (int i = 0; i < 5; i++) begin
            model_txn(wes[i], f3s[i], adr[i], 32'hFFFFFFFF, erd, eer);
            do_txn(wes[i], f3s[i], adr[i], 32'hFFFFFFFF, rd, er, lat);
            total += 2;
            if (er !== 1'b1) begin bad++; $display("FAIL fault_err we=%b f3=%0d @%h: got %b required 1", wes[i], f3s[i], adr[i], er); end
            if (rd !== 32'h0) begin bad++; $display("FAIL fault_data we=%b f3=%0d @%h: got %h required 0", wes[i], f3s[i], adr[i], rd); end
            $display("fault we=%b f3=%0d @%h -> err=%b", wes[i], f3s[i], adr[i], er);
        end
        do_txn(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'hBBCCAA44) begin bad++; $display("FAIL fault_no_write_20: got %h required bbccaa44", rd); end
        model_txn(1'b0, F3_W, 32'h00, 32'h0, erd, eer);
        do_txn(1'b0, F3_W, 32'h00, 32'h0, rd, er, lat);
        total++;
        if (rd !== erd) begin bad++; $display("FAIL fault_no_write_00: got %h required %h", rd, erd); end
    endtask

    task automatic test_hold;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        issue(1'b0, F3_W, 32'h10, 32'h0);
        total++;
        if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL hold_busy_ready: got %b required 0", bus.req_ready); end
        wait_rsp(lat);
        total++;
        if (lat != LAT + 1) begin bad++; $display("FAIL hold_latency: got %0d required %0d", lat, LAT + 1); end
        // stall the response and offer a stray store that must be ignored
        for (int c = 0; c < 5; c++) begin
            bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = F3_W;
            bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
            total += 3;
            if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c=%0d: got %b required 1", c, bus.rsp_valid); end
            if (bus.rsp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL hold_data c=%0d: got %h required deadbeef", c, bus.rsp_rdata); end
            if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL hold_ready c=%0d: got %b required 0", c, bus.req_ready); end
            @(negedge CLK);
        end
        bus.req_valid = 1'b0;
        finish_rsp();
        total += 2;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL release_valid: got %b required 0", bus.rsp_valid); end
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got %b required 1", bus.req_ready); end
        model_txn(1'b0, F3_W, 32'h10, 32'h0, erd, eer);
        do_txn(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat);
        total++;
        if (rd !== erd) begin bad++; $display("FAIL hold_ignored_store: got %h required %h", rd, erd); end
        $display("hold: latency=%0d data=%h", lat, rd);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        model_txn(1'b1, F3_W, 32'h40, 32'h55, erd, eer);
        issue(1'b1, F3_W, 32'h40, 32'h55);
        rst = 1'b0;
        #1;
        total += 2;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b required 0", bus.rsp_valid); end
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b required 1", bus.req_ready); end
        @(negedge CLK);
        rst = 1'b1;
        do_txn(1'b0, F3_W, 32'h40, 32'h0, rd, er, lat);
        total++;
        if (rd !== 32'h00000055) begin bad++; $display("FAIL midrst_store_kept: got %h required 00000055", rd); end
        $display("reset mid-wait: LW @40 -> %h", rd);
    endtask

    task automatic test_random;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd, erd;
        logic er, eer;
        int lat;
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(1));
            f3 = 3'($urandom_range(7));
            a  = 32'($urandom_range(63) * 4);
            if ($urandom_range(2) == 0) a = a + 32'($urandom_range(3));
            wd = $urandom;
            model_txn(we, f3, a, wd, erd, eer);
            do_txn(we, f3, a, wd, rd, er, lat);
            total += 3;
            if (rd !== erd) begin bad++; $display("FAIL rand_data #%0d we=%b f3=%0d @%h: got %h required %h", i, we, f3, a, rd, erd); end
            if (er !== eer) begin bad++; $display("FAIL rand_err #%0d we=%b f3=%0d @%h: got %b required %b", i, we, f3, a, er, eer); end
            if (lat != LAT + 1) begin bad++; $display("FAIL rand_lat #%0d: got %0d required %0d", i, lat, LAT + 1); end
            $display("txn %0d we=%b f3=%0d @%h wd=%h -> rd=%h err=%b", i, we, f3, a, wd, rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_sized_loads();
        test_range();
        test_partial_stores();
        test_faults();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
